// File: rtl/rr_arbiter_onehot.sv
// Round-robin arbiter with a registered one-hot grant that stays locked until ack_i.
// Optional grant watchdog enabled by defining RR_ARB_TIMEOUT_EN.
module rr_arbiter_onehot #(
    parameter int unsigned N_REQ       = 8,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_REQ-1:0] req_i,
    input  logic             ack_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic             gnt_valid_o,
    output logic             timeout_o
);

    localparam int unsigned PTR_W = $clog2(N_REQ);

    if (N_REQ < 2 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("rr_arbiter_onehot: need N_REQ >= 2 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win_q, win_d;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] pick;
    logic             release_grant;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             wd_hit;
`endif

    // First set request scanning upward from ptr, wrapping modulo N_REQ.
    function automatic logic [PTR_W-1:0] pick_idx(input logic [N_REQ-1:0] req,
                                                   input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] idx;
        logic             found;
        int unsigned      j;
        idx   = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            j = (32'(ptr) + i) % N_REQ;
            if (!found && req[j]) begin
                idx   = PTR_W'(j);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        ptr_d         = ptr_q;
        win_d         = win_q;
        release_grant = ack_i;
`ifdef RR_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_d     = 1'b0;
        // Fires on the last allowed cycle so the grant lasts exactly TIMEOUT_CYC cycles.
        wd_hit        = (state_q == GRANT) && !ack_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
        release_grant = ack_i | wd_hit;
`endif
        rr_ptr = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + PTR_W'(1);
        pick   = pick_idx(req_i, (state_q == GRANT) ? rr_ptr : ptr_q);

        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
                    win_d   = pick;
                    state_d = GRANT;
`ifdef RR_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
                if (release_grant) begin
                    // Rotate past the winner and re-arbitrate in the same cycle.
                    ptr_d = rr_ptr;
`ifdef RR_ARB_TIMEOUT_EN
                    timeout_d = wd_hit;
`endif
                    if (|req_i) begin
                        gnt_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
                        win_d = pick;
`ifdef RR_ARB_TIMEOUT_EN
                        cnt_d = '0;
`endif
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
`ifdef RR_ARB_TIMEOUT_EN
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ptr_q     <= '0;
            win_q     <= '0;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = (state_q == GRANT);
`ifdef RR_ARB_TIMEOUT_EN
    assign timeout_o   = timeout_q;
`else
    assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_onehot.sv
// Self-checking bench for rr_arbiter_onehot (N_REQ=8, TIMEOUT_CYC=16).
module tb_rr_arbiter_onehot;

    localparam int unsigned N = 8;

    logic         clk;
    logic         rst_ni;
    logic [N-1:0] req;
    logic         ack;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic         timeout;

    int checks;
    int errors;
    int inv_errors;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] exp;

    rr_arbiter_onehot #(.N_REQ(N), .TIMEOUT_CYC(16)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .req_i      (req),
        .ack_i      (ack),
        .gnt_o      (gnt),
        .gnt_valid_o(gnt_valid),
        .timeout_o  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Grant must be one-hot-or-zero and valid must track it on every cycle.
    always @(negedge clk) begin
        if (rst_ni === 1'b1) begin
            if (!$onehot0(gnt) || (gnt_valid !== (|gnt))) begin
                inv_errors++;
                $display("FAIL invariant t=%0t gnt=%b valid=%b", $time, gnt, gnt_valid);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        req    = '0;
        ack    = 1'b0;
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        req    = 8'hFF;
        ack    = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({gnt, gnt_valid, timeout} !== 10'd0) begin
                errors++;
                $display("FAIL reset[%0d] gnt=%h valid=%b timeout=%b expected all 0", i, gnt, gnt_valid, timeout);
            end
            tick();
        end
        req    = '0;
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int bin;
        apply_reset();
        req = 8'b0010_0000;
        exp_q.push_back(8'b0010_0000);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (gnt !== exp || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL single gnt=%b valid=%b expected %b valid=1", gnt, gnt_valid, exp);
        end
        bin = -1;
        for (int i = 0; i < N; i++) if (gnt[i]) bin = i;
        checks++;
        if (bin != 5) begin
            errors++;
            $display("FAIL single_bin index=%0d expected 5", bin);
        end
        ack = 1'b1;
        req = '0;
        exp_q.push_back(8'h00);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (gnt !== exp || gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_release gnt=%b valid=%b expected 0", gnt, gnt_valid);
        end
        ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] one;
        apply_reset();
        req = 8'hFF;
        exp_q.push_back(8'h01);
        tick();
        ack = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            exp = exp_q.pop_front();
            checks++;
            if (gnt !== exp) begin
                errors++;
                $display("FAIL rotate[%0d] gnt=%h expected %h", k - 1, gnt, exp);
            end
            if (k <= 8) begin
                one = 8'h01;
                exp_q.push_back(one << (k % 8));
                tick();
            end
        end
        req = '0;
        exp_q.push_back(8'h00);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (gnt !== exp || gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL rotate_idle gnt=%h valid=%b expected 0", gnt, gnt_valid);
        end
        ack = 1'b0;
    endtask

    task automatic test_wrap_hold();
        logic [N-1:0] reqs[6] = '{8'h80, 8'h81, 8'h01, 8'h81, 8'h81, 8'h00};
        logic         acks[6] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
        logic [N-1:0] exps[6] = '{8'h80, 8'h80, 8'h80, 8'h01, 8'h80, 8'h00};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            req = reqs[i];
            ack = acks[i];
            exp_q.push_back(exps[i]);
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (gnt !== exp) begin
                errors++;
                $display("FAIL wrap_hold[%0d] gnt=%h expected %h", i, gnt, exp);
            end
        end
        ack = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        req = 8'h10;
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if (gnt !== 8'h10) begin
            errors++;
            $display("FAIL async_setup gnt=%h expected 10", gnt);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_drop gnt=%h valid=%b expected 0", gnt, gnt_valid);
        end
        tick();
        rst_ni = 1'b1;
        req    = 8'h44;
        exp_q.push_back(8'h04);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (gnt !== exp) begin
            errors++;
            $display("FAIL async_ptr gnt=%h expected %h", gnt, exp);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        req = 8'h03;
        ack = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        for (int c = 1; c <= 18; c++) begin
            exp_q.push_back((c <= 16) ? 8'h01 : 8'h02);
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (gnt !== exp || timeout !== (c == 17)) begin
                errors++;
                $display("FAIL timeout[%0d] gnt=%h timeout=%b expected %h timeout=%b", c, gnt, timeout, exp, (c == 17));
            end
        end
`else
        for (int c = 1; c <= 100; c++) begin
            exp_q.push_back(8'h01);
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (gnt !== exp || timeout !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d] gnt=%h timeout=%b expected %h timeout=0", c, gnt, timeout, exp);
            end
        end
`endif
        req = '0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_invariants();
        checks++;
        if (inv_errors !== 0) begin
            errors++;
            $display("FAIL invariants count=%0d expected 0", inv_errors);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard leftover=%0d expected 0", exp_q.size());
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        inv_errors = 0;
        rst_ni     = 1'b0;
        req        = '0;
        ack        = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap_hold();
        test_async_reset();
        test_timeout();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
